// File: rtl/sram_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the SRAM macro.
// The arbiter takes the slave view; the core and SRAM side take the master view.
interface sram_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  sram_rdata,
        output inst_ack, inst_rvalid, inst_rdata,
        output data_ack, data_rvalid, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output sram_rdata,
        input  inst_ack, inst_rvalid, inst_rdata,
        input  data_ack, data_rvalid, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one synchronous-read SRAM between instruction fetch and load/store.
// Data has priority; a saturating counter forces a fetch grant after STARVE_LIMIT contended data wins.
module sram_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus
);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_tag_inst;
    logic             r_tag_data;
    logic [31:0]      r_inst_hold;
    logic [31:0]      r_data_hold;

    logic w_starve_ok;
    logic w_data_grant;
    logic w_inst_grant;
    logic w_inst_rvalid;
    logic w_data_rvalid;

    // Signed compare keeps STARVE_LIMIT=0 meaningful: data then never wins a conflict.
    assign w_starve_ok   = int'(r_starve_cnt) < STARVE_LIMIT;
    assign w_data_grant  = !reset && bus.data_req && (!bus.inst_req || w_starve_ok);
    assign w_inst_grant  = !reset && bus.inst_req && !w_data_grant;

    assign bus.inst_ack  = w_inst_grant;
    assign bus.data_ack  = w_data_grant;
    assign bus.sram_en   = w_inst_grant || w_data_grant;
    assign bus.sram_we   = (w_data_grant && bus.data_wr) ? bus.data_wstrb : 4'b0000;
    assign bus.sram_wdata = w_data_grant ? bus.data_wdata : 32'h0;
    assign bus.sram_addr = w_data_grant ? bus.data_addr :
                           w_inst_grant ? bus.inst_addr : 32'h0;

    assign w_inst_rvalid   = r_tag_inst && !reset;
    assign w_data_rvalid   = r_tag_data && !reset;
    assign bus.inst_rvalid = w_inst_rvalid;
    assign bus.data_rvalid = w_data_rvalid;
    assign bus.inst_rdata  = w_inst_rvalid ? bus.sram_rdata : r_inst_hold;
    assign bus.data_rdata  = w_data_rvalid ? bus.sram_rdata : r_data_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!bus.inst_req || w_inst_grant) begin
            r_starve_cnt <= '0;
        end else if (w_data_grant && w_starve_ok) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    // Tags mark which requester owns the SRAM read data arriving next cycle; stores set none.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_inst <= 1'b0;
            r_tag_data <= 1'b0;
        end else begin
            r_tag_inst <= w_inst_grant;
            r_tag_data <= w_data_grant && !bus.data_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst_hold <= 32'h0;
            r_data_hold <= 32'h0;
        end else begin
            if (w_inst_rvalid) r_inst_hold <= bus.sram_rdata;
            if (w_data_rvalid) r_data_hold <= bus.sram_rdata;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, single fetch, contention, starvation,
// stores, reset during an outstanding read, and the STARVE_LIMIT=0 variant.
module tb_sram_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sram_arbiter_if u_if  ();
    sram_arbiter_if u_if0 ();

    sram_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    sram_arbiter #(.STARVE_LIMIT(0), .CNT_W(3)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        u_if.inst_req   = 1'b0;
        u_if.inst_addr  = 32'h0;
        u_if.data_req   = 1'b0;
        u_if.data_wr    = 1'b0;
        u_if.data_wstrb = 4'h0;
        u_if.data_addr  = 32'h0;
        u_if.data_wdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        u_if.sram_rdata = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if ({u_if.inst_ack, u_if.data_ack, u_if.sram_en, u_if.sram_we,
                 u_if.inst_rvalid, u_if.data_rvalid} !== 9'b0) begin
                failures++;
                $display("[TB] FAIL reset_ctrl cycle %0d: got %b expected 0", i,
                         {u_if.inst_ack, u_if.data_ack, u_if.sram_en, u_if.sram_we,
                          u_if.inst_rvalid, u_if.data_rvalid});
            end
            checks++;
            if ({u_if.sram_addr, u_if.sram_wdata, u_if.inst_rdata, u_if.data_rdata} !== 128'h0) begin
                failures++;
                $display("[TB] FAIL reset_data cycle %0d: got addr=%h wdata=%h irdata=%h drdata=%h expected 0",
                         i, u_if.sram_addr, u_if.sram_wdata, u_if.inst_rdata, u_if.data_rdata);
            end
            tick();
        end
    endtask

    task automatic test_single_fetch();
        u_if.inst_req  = 1'b1;
        u_if.inst_addr = 32'h1c000000;
        settle();
        checks++;
        if ({u_if.inst_ack, u_if.data_ack, u_if.sram_en, u_if.sram_we} !== 7'b1010000 ||
            u_if.sram_addr !== 32'h1c000000) begin
            failures++;
            $display("[TB] FAIL fetch_issue: got ack=%b%b en=%b we=%b addr=%h expected 1 0 1 0 1c000000",
                     u_if.inst_ack, u_if.data_ack, u_if.sram_en, u_if.sram_we, u_if.sram_addr);
        end
        tick();
        u_if.inst_req   = 1'b0;
        u_if.sram_rdata = 32'h02804006;
        settle();
        checks++;
        if (u_if.inst_rvalid !== 1'b1 || u_if.inst_rdata !== 32'h02804006 ||
            u_if.data_rvalid !== 1'b0 || u_if.sram_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fetch_return: got irv=%b irdata=%h drv=%b en=%b expected 1 02804006 0 0",
                     u_if.inst_rvalid, u_if.inst_rdata, u_if.data_rvalid, u_if.sram_en);
        end
        tick();
        u_if.sram_rdata = 32'h11111111;
        settle();
        checks++;
        if (u_if.inst_rvalid !== 1'b0 || u_if.inst_rdata !== 32'h02804006) begin
            failures++;
            $display("[TB] FAIL fetch_hold: got irv=%b irdata=%h expected 0 02804006",
                     u_if.inst_rvalid, u_if.inst_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        u_if.inst_req  = 1'b1;
        u_if.inst_addr = 32'h1c000004;
        u_if.data_req  = 1'b1;
        u_if.data_wr   = 1'b0;
        u_if.data_addr = 32'h1c001000;
        settle();
        checks++;
        if (u_if.data_ack !== 1'b1 || u_if.inst_ack !== 1'b0 ||
            u_if.sram_addr !== 32'h1c001000 || u_if.sram_we !== 4'h0) begin
            failures++;
            $display("[TB] FAIL contend_data_wins: got dack=%b iack=%b addr=%h we=%b expected 1 0 1c001000 0000",
                     u_if.data_ack, u_if.inst_ack, u_if.sram_addr, u_if.sram_we);
        end
        tick();
        u_if.data_req   = 1'b0;
        u_if.sram_rdata = 32'ha5a50001;
        settle();
        checks++;
        if (u_if.data_rvalid !== 1'b1 || u_if.data_rdata !== 32'ha5a50001 ||
            u_if.inst_ack !== 1'b1 || u_if.sram_addr !== 32'h1c000004) begin
            failures++;
            $display("[TB] FAIL contend_inst_next: got drv=%b drdata=%h iack=%b addr=%h expected 1 a5a50001 1 1c000004",
                     u_if.data_rvalid, u_if.data_rdata, u_if.inst_ack, u_if.sram_addr);
        end
        tick();
        u_if.inst_req   = 1'b0;
        u_if.sram_rdata = 32'h0badf00d;
        settle();
        checks++;
        if (u_if.inst_rvalid !== 1'b1 || u_if.inst_rdata !== 32'h0badf00d ||
            u_if.data_rvalid !== 1'b0 || u_if.data_rdata !== 32'ha5a50001) begin
            failures++;
            $display("[TB] FAIL contend_steer: got irv=%b irdata=%h drv=%b drdata=%h expected 1 0badf00d 0 a5a50001",
                     u_if.inst_rvalid, u_if.inst_rdata, u_if.data_rvalid, u_if.data_rdata);
        end
        tick();
    endtask

    // Both requests held for 10 cycles: pattern D D D D I repeats.
    task automatic test_starvation();
        int inst_grants;
        logic [1:0] exp_acks;
        inst_grants = 0;
        u_if.inst_req  = 1'b1;
        u_if.inst_addr = 32'h1c000008;
        u_if.data_req  = 1'b1;
        u_if.data_wr   = 1'b0;
        u_if.data_addr = 32'h1c001004;
        for (int i = 0; i < 10; i++) begin
            settle();
            exp_acks = ((i % 5) == 4) ? 2'b10 : 2'b01;
            if (u_if.inst_ack === 1'b1) inst_grants++;
            checks++;
            if ({u_if.inst_ack, u_if.data_ack} !== exp_acks) begin
                failures++;
                $display("[TB] FAIL starve_pattern cycle %0d: got {iack,dack}=%b expected %b",
                         i, {u_if.inst_ack, u_if.data_ack}, exp_acks);
            end
            tick();
        end
        checks++;
        if (inst_grants != 2) begin
            failures++;
            $display("[TB] FAIL starve_count: got %0d inst grants expected 2", inst_grants);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_store();
        u_if.data_req  = 1'b1;
        u_if.data_wr   = 1'b0;
        u_if.data_addr = 32'h1c002000;
        tick();
        u_if.data_req   = 1'b0;
        u_if.sram_rdata = 32'h12345678;
        settle();
        checks++;
        if (u_if.data_rvalid !== 1'b1 || u_if.data_rdata !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL store_preload: got drv=%b drdata=%h expected 1 12345678",
                     u_if.data_rvalid, u_if.data_rdata);
        end
        tick();
        u_if.data_req   = 1'b1;
        u_if.data_wr    = 1'b1;
        u_if.data_wstrb = 4'b0011;
        u_if.data_addr  = 32'h1c002004;
        u_if.data_wdata = 32'hdeadbeef;
        settle();
        checks++;
        if (u_if.data_ack !== 1'b1 || u_if.sram_en !== 1'b1 || u_if.sram_we !== 4'b0011 ||
            u_if.sram_wdata !== 32'hdeadbeef || u_if.sram_addr !== 32'h1c002004) begin
            failures++;
            $display("[TB] FAIL store_issue: got dack=%b en=%b we=%b wdata=%h addr=%h expected 1 1 0011 deadbeef 1c002004",
                     u_if.data_ack, u_if.sram_en, u_if.sram_we, u_if.sram_wdata, u_if.sram_addr);
        end
        tick();
        u_if.data_wstrb = 4'b0000;
        u_if.sram_rdata = 32'hffffffff;
        settle();
        checks++;
        if (u_if.data_rvalid !== 1'b0 || u_if.data_rdata !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL store_no_rvalid: got drv=%b drdata=%h expected 0 12345678",
                     u_if.data_rvalid, u_if.data_rdata);
        end
        checks++;
        if (u_if.data_ack !== 1'b1 || u_if.sram_en !== 1'b1 || u_if.sram_we !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL store_zero_strb: got dack=%b en=%b we=%b expected 1 1 0000",
                     u_if.data_ack, u_if.sram_en, u_if.sram_we);
        end
        tick();
        idle_inputs();
        settle();
        checks++;
        if (u_if.data_rvalid !== 1'b0 || u_if.sram_wdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL store_zero_after: got drv=%b wdata=%h expected 0 0",
                     u_if.data_rvalid, u_if.sram_wdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        logic [1:0] exp_acks;
        u_if.inst_req  = 1'b1;
        u_if.inst_addr = 32'h1c00000c;
        u_if.data_req  = 1'b1;
        u_if.data_wr   = 1'b0;
        u_if.data_addr = 32'h1c003000;
        tick();
        tick();
        settle();
        checks++;
        if (u_if.data_ack !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_load: got dack=%b expected 1", u_if.data_ack);
        end
        tick();
        reset           = 1'b1;
        u_if.data_req   = 1'b0;
        u_if.sram_rdata = 32'h77777777;
        settle();
        checks++;
        if (u_if.data_rvalid !== 1'b0 || u_if.inst_ack !== 1'b0 || u_if.sram_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_suppress: got drv=%b iack=%b en=%b expected 0 0 0",
                     u_if.data_rvalid, u_if.inst_ack, u_if.sram_en);
        end
        tick();
        reset         = 1'b0;
        u_if.data_req = 1'b1;
        settle();
        checks++;
        if (u_if.data_rdata !== 32'h0 || u_if.data_rvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_rdata: got drdata=%h drv=%b expected 0 0",
                     u_if.data_rdata, u_if.data_rvalid);
        end
        for (int i = 0; i < 5; i++) begin
            if (i != 0) settle();
            exp_acks = (i == 4) ? 2'b10 : 2'b01;
            checks++;
            if ({u_if.inst_ack, u_if.data_ack} !== exp_acks) begin
                failures++;
                $display("[TB] FAIL midreset_starve cycle %0d: got {iack,dack}=%b expected %b",
                         i, {u_if.inst_ack, u_if.data_ack}, exp_acks);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_limit_zero();
        u_if0.inst_req  = 1'b1;
        u_if0.inst_addr = 32'h1c000010;
        u_if0.data_req  = 1'b1;
        u_if0.data_wr   = 1'b0;
        u_if0.data_addr = 32'h1c004000;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if ({u_if0.inst_ack, u_if0.data_ack} !== 2'b10) begin
                failures++;
                $display("[TB] FAIL limit0_contend cycle %0d: got {iack,dack}=%b expected 10",
                         i, {u_if0.inst_ack, u_if0.data_ack});
            end
            tick();
        end
        u_if0.inst_req = 1'b0;
        settle();
        checks++;
        if ({u_if0.inst_ack, u_if0.data_ack} !== 2'b01 || u_if0.sram_addr !== 32'h1c004000) begin
            failures++;
            $display("[TB] FAIL limit0_data_alone: got {iack,dack}=%b addr=%h expected 01 1c004000",
                     {u_if0.inst_ack, u_if0.data_ack}, u_if0.sram_addr);
        end
        tick();
        u_if0.data_req = 1'b0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        u_if0.inst_req   = 1'b0;
        u_if0.inst_addr  = 32'h0;
        u_if0.data_req   = 1'b0;
        u_if0.data_wr    = 1'b0;
        u_if0.data_wstrb = 4'h0;
        u_if0.data_addr  = 32'h0;
        u_if0.data_wdata = 32'h0;
        u_if0.sram_rdata = 32'h0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_store();
        test_reset_mid_read();
        test_limit_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one synchronous-read SRAM between the instruction-fetch port and the load/store port of the multi-cycle core.
- Decides a grant in the same cycle as the request and issues at most one SRAM access per cycle.
- Returns read data one cycle after issue, steered to the requester that issued the read.
- Data accesses have priority; a bounded anti-starvation counter guarantees instruction fetch forward progress.

Parameters:
- STARVE_LIMIT, 4: consecutive contended data wins allowed before inst is forced to win; 0 = inst wins every conflict.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W-1 >= STARVE_LIMIT.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- inst_req  input  1  fetch request, held until inst_ack
- inst_addr  input  32  fetch byte address
- inst_ack  output  1  fetch granted this cycle
- inst_rvalid  output  1  inst_rdata valid (cycle after inst_ack)
- inst_rdata  output  32  fetched word
- data_req  input  1  load/store request, held until data_ack
- data_wr  input  1  1 = store, 0 = load
- data_wstrb  input  4  byte enables for a store
- data_addr  input  32  load/store byte address
- data_wdata  input  32  store data
- data_ack  output  1  load/store granted this cycle
- data_rvalid  output  1  data_rdata valid (cycle after a load ack)
- data_rdata  output  32  loaded word
- sram_en  output  1  SRAM access this cycle
- sram_we  output  4  SRAM byte write enables
- sram_addr  output  32  SRAM address
- sram_wdata  output  32  SRAM write data
- sram_rdata  input  32  SRAM read data, valid the cycle after the read is issued

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Grant logic is combinational from the req inputs and starve_cnt:
  - Only one req high: that requester wins.
  - Both high: data wins if starve_cnt < STARVE_LIMIT; otherwise inst wins.
  - Neither high: no grant; sram_en=0, sram_we=0.
- A winner gets its ack=1 in the same cycle, with sram_en=1 and sram_addr = winner addr (addr[1:0] passed unaltered, no alignment check).
  - Inst winner: sram_we=0.
  - Data winner: sram_we = data_wr ? data_wstrb : 4'b0, and sram_wdata = data_wdata.
  - With no data grant, sram_wdata = 0.
- Loser keeps its ack=0 and must hold its req and payload stable; it is re-arbitrated next cycle.
- Throughput is one access per cycle. Back-to-back acks to the same requester are legal.
- starve_cnt register:
  - Increments, saturating at STARVE_LIMIT, when data wins while inst_req=1.
  - Clears to 0 when inst is granted, or in any cycle with inst_req=0.
  - Otherwise holds.
- Read return tag register: captures {inst_read_issued, data_read_issued} each cycle. A data store sets no tag.
- In the cycle after the access:
  - inst_rvalid = tag_inst.
  - data_rvalid = tag_data.
  - The flagged rdata output equals sram_rdata combinationally.
- inst_rdata and data_rdata each hold the last returned value while their rvalid=0. Each has a hold register, loaded when its rvalid=1.
- Store with data_wstrb=0 is still acked and occupies the cycle; no SRAM byte changes, no rvalid.
- Reset:
  - While reset=1, all acks, sram_en, sram_we and both rvalids are forced to 0 combinationally. This covers a read issued the cycle before reset rises, which must not produce rvalid.
  - At the reset edge: starve_cnt=0, tags=0, both rdata hold registers=0.
  - Output values after reset: acks 0, rvalids 0, rdata 0, sram_en 0, sram_we 0, sram_addr 0, sram_wdata 0 (with no req).
- The first grant is possible in the first cycle with reset=0.
- No state depends on addr; there are no internal buffers. A requester that drops req without an ack has its request cancelled.

Test Plan:
- Reset then idle: all outputs 0 for 3 cycles. Raise inst_req, addr 0x1c000000 -> inst_ack=1 same cycle, sram_addr=0x1c000000, sram_we=0. Next cycle inst_rvalid=1 and inst_rdata=sram_rdata (drive 0x02804006).
- Simultaneous req, load addr 0x1c001000 vs fetch 0x1c000004 -> data_ack=1, inst_ack=0, data_rvalid next cycle. Inst wins the following cycle once data_req drops.
- Continuous data_req and inst_req with STARVE_LIMIT=4 -> data acked 4 cycles, inst acked cycle 5, data cycle 6. Pattern repeats: exactly 1 inst grant per 5 cycles.
- Store with data_wstrb=4'b0011, wdata 0xdeadbeef -> sram_we=4'b0011, sram_wdata=0xdeadbeef, data_ack=1, no data_rvalid next cycle. data_rdata keeps its previous value.
- Load acked in cycle N, reset=1 in cycle N+1 -> data_rvalid=0 in N+1. After reset, data_rdata=0 and starve_cnt behaves from 0.
- STARVE_LIMIT=0 with both requests held -> inst_ack every contended cycle, data_ack only in cycles with inst_req=0.
